// File: rtl/intr_prio_sched.sv
// Edge-captured interrupt scheduler: 16 sources ranked by programmable priority, one winner held until acked.
// Optional build macro INTR_RR_TIEBREAK_EN selects round-robin resolution of equal-priority ties.
module intr_prio_sched #(
    parameter int NUM_INTR = 16,
    parameter int PRIO_W   = 4
) (
    input  logic                pclk_i,
    input  logic                prst_i,
    input  logic [7:0]          paddr_i,
    input  logic [7:0]          pwdata_i,
    input  logic                pwrite_i,
    input  logic                penable_i,
    output logic [7:0]          prdata_o,
    output logic                pready_o,
    output logic                perror_o,
    input  logic [NUM_INTR-1:0] intr_active_i,
    output logic                intr_valid_o,
    output logic [3:0]          intr_to_service_o,
    input  logic                intr_serviced_i
);
    localparam int ID_W = 4;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARB = 2'd1, S_WAIT = 2'd2} state_t;

    state_t                           state_q, state_d;
    logic [NUM_INTR-1:0]              pending_q, pending_d;
    logic [NUM_INTR-1:0]              intr_prev_q, intr_prev_d;
    logic [NUM_INTR-1:0][PRIO_W-1:0]  prio_q, prio_d;
    logic [ID_W-1:0]                  id_q, id_d;
    logic                             valid_q, valid_d;
    logic [7:0]                       prdata_q, prdata_d;
    logic                             pready_q, pready_d;
    logic                             perror_q, perror_d;
    logic [NUM_INTR-1:0]              clr;
    logic                             win_found;
    logic [ID_W-1:0]                  win_id;
    logic [PRIO_W-1:0]                win_prio;
    logic [15:0]                      pend16;
    logic [7:0]                       rd_val;
    logic                             unused_wdata;
`ifdef INTR_RR_TIEBREAK_EN
    logic [ID_W-1:0]                  last_q, last_d;
    int                               idx;
`endif

    assign unused_wdata = ^pwdata_i;
    assign pend16       = 16'(pending_q);

    // Strict '>' keeps the first candidate met in search order, so ties go to the search start.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_prio  = '0;
`ifdef INTR_RR_TIEBREAK_EN
        idx = 0;
        for (int k = 0; k < NUM_INTR; k++) begin
            idx = (int'(last_q) + 1 + k) % NUM_INTR;
            if (pending_q[idx] && prio_q[idx] > win_prio) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
                win_prio  = prio_q[idx];
            end
        end
`else
        for (int n = 0; n < NUM_INTR; n++) begin
            if (pending_q[n] && prio_q[n] > win_prio) begin
                win_found = 1'b1;
                win_id    = ID_W'(n);
                win_prio  = prio_q[n];
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        valid_d = valid_q;
        clr     = '0;
`ifdef INTR_RR_TIEBREAK_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: if (win_found) state_d = S_ARB;
            S_ARB: begin
                if (win_found) begin
                    state_d = S_WAIT;
                    id_d    = win_id;
                    valid_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (intr_serviced_i) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    clr     = NUM_INTR'(1) << id_q;
`ifdef INTR_RR_TIEBREAK_EN
                    last_d  = id_q;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
        intr_prev_d = intr_active_i;
        // A fresh edge in the clear cycle wins over the clear.
        pending_d   = (pending_q & ~clr) | (intr_active_i & ~intr_prev_q);
    end

    always_comb begin
        rd_val = '0;
        if (paddr_i < 8'(NUM_INTR)) rd_val = 8'(prio_q[paddr_i[3:0]]);
        else if (paddr_i == 8'h10)  rd_val = pend16[7:0];
        else if (paddr_i == 8'h11)  rd_val = pend16[15:8];
        else if (paddr_i == 8'h12)  rd_val = {valid_q, 3'b000, id_q};
    end

    always_comb begin
        pready_d = penable_i;
        perror_d = 1'b0;
        prdata_d = prdata_q;
        prio_d   = prio_q;
        if (penable_i) begin
            if (pwrite_i) begin
                if (paddr_i >= 8'h10)
                    perror_d = 1'b1;
                else if (paddr_i < 8'(NUM_INTR))
                    prio_d[paddr_i[3:0]] = pwdata_i[PRIO_W-1:0];
            end else begin
                perror_d = (paddr_i > 8'h12);
                prdata_d = rd_val;
            end
        end
    end

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            intr_prev_q <= '0;
            prio_q      <= '0;
            id_q        <= '0;
            valid_q     <= 1'b0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            perror_q    <= 1'b0;
`ifdef INTR_RR_TIEBREAK_EN
            last_q      <= ID_W'(NUM_INTR - 1);
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            intr_prev_q <= intr_prev_d;
            prio_q      <= prio_d;
            id_q        <= id_d;
            valid_q     <= valid_d;
            prdata_q    <= prdata_d;
            pready_q    <= pready_d;
            perror_q    <= perror_d;
`ifdef INTR_RR_TIEBREAK_EN
            last_q      <= last_d;
`endif
        end
    end

    assign prdata_o          = prdata_q;
    assign pready_o          = pready_q;
    assign perror_o          = perror_q;
    assign intr_valid_o      = valid_q;
    assign intr_to_service_o = id_q;
endmodule

// File: tb/tb_intr_prio_sched.sv
// Directed bench for intr_prio_sched (default build): register access, arbitration order, masking, corners.
module tb_intr_prio_sched;
    logic        pclk_i = 1'b0;
    logic        prst_i;
    logic [7:0]  paddr_i, pwdata_i, prdata_o;
    logic        pwrite_i, penable_i, pready_o, perror_o;
    logic [15:0] intr_active_i;
    logic        intr_valid_o, intr_serviced_i;
    logic [3:0]  intr_to_service_o;

    int errors = 0;
    int checks = 0;

    intr_prio_sched #(.NUM_INTR(16), .PRIO_W(4)) dut (
        .pclk_i(pclk_i), .prst_i(prst_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
        .pwrite_i(pwrite_i), .penable_i(penable_i), .prdata_o(prdata_o),
        .pready_o(pready_o), .perror_o(perror_o), .intr_active_i(intr_active_i),
        .intr_valid_o(intr_valid_o), .intr_to_service_o(intr_to_service_o),
        .intr_serviced_i(intr_serviced_i)
    );

    always #5 pclk_i = ~pclk_i;

    task automatic tick();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d, input logic exp_err, input string tag);
        paddr_i = a; pwdata_i = d; pwrite_i = 1'b1; penable_i = 1'b1;
        tick();
        penable_i = 1'b0; pwrite_i = 1'b0;
        chk({tag, "_rdy"}, 32'(pready_o), 32'd1);
        chk({tag, "_err"}, 32'(perror_o), 32'(exp_err));
    endtask

    task automatic apb_read(input logic [7:0] a, input logic [7:0] exp_d, input logic exp_err, input string tag);
        paddr_i = a; pwrite_i = 1'b0; penable_i = 1'b1;
        tick();
        penable_i = 1'b0;
        chk({tag, "_rdy"}, 32'(pready_o), 32'd1);
        chk({tag, "_err"}, 32'(perror_o), 32'(exp_err));
        if (!exp_err) chk({tag, "_data"}, 32'(prdata_o), 32'(exp_d));
    endtask

    task automatic service();
        intr_serviced_i = 1'b1;
        tick();
        intr_serviced_i = 1'b0;
    endtask

    task automatic chk_win(input logic exp_v, input logic [3:0] exp_id, input string tag);
        chk({tag, "_valid"}, 32'(intr_valid_o), 32'(exp_v));
        if (exp_v) chk({tag, "_id"}, 32'(intr_to_service_o), 32'(exp_id));
    endtask

    initial begin
        prst_i = 1'b1; paddr_i = '0; pwdata_i = '0; pwrite_i = 1'b0; penable_i = 1'b0;
        intr_active_i = '0; intr_serviced_i = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(intr_valid_o), 32'd0);
        chk("rst_id", 32'(intr_to_service_o), 32'd0);
        chk("rst_rdy", 32'(pready_o), 32'd0);
        chk("rst_err", 32'(perror_o), 32'd0);
        chk("rst_rdata", 32'(prdata_o), 32'd0);
        prst_i = 1'b0;
        tick();

        // Register access and read-data hold
        apb_write(8'h03, 8'h05, 1'b0, "wr_prio3");
        apb_read(8'h03, 8'h05, 1'b0, "rd_prio3");
        tick();
        chk("rdy_pulse", 32'(pready_o), 32'd0);
        chk("rdata_hold", 32'(prdata_o), 32'h05);

        // Single interrupt, latency of two clocks after the sampling edge
        intr_active_i[3] = 1'b1;
        tick(); chk_win(1'b0, 4'd0, "lat_k");
        tick(); chk_win(1'b0, 4'd0, "lat_k1");
        tick(); chk_win(1'b1, 4'd3, "lat_k2");
        apb_read(8'h10, 8'h08, 1'b0, "pend_single");
        apb_read(8'h12, 8'h83, 1'b0, "status_single");
        service();
        chk_win(1'b0, 4'd0, "svc_single");
        apb_read(8'h10, 8'h00, 1'b0, "pend_cleared");
        tick(); tick();
        chk_win(1'b0, 4'd0, "level_no_retrigger");
        intr_active_i[3] = 1'b0;

        // Priority ordering
        apb_write(8'h02, 8'h01, 1'b0, "wr_prio2");
        apb_write(8'h09, 8'h07, 1'b0, "wr_prio9");
        intr_active_i[2] = 1'b1; intr_active_i[9] = 1'b1;
        tick(); tick(); tick();
        chk_win(1'b1, 4'd9, "prio_first");
        apb_read(8'h10, 8'h04, 1'b0, "pend_lo_two");
        apb_read(8'h11, 8'h02, 1'b0, "pend_hi_two");
        service();
        chk_win(1'b0, 4'd0, "prio_gap");
        tick(); tick();
        chk_win(1'b1, 4'd2, "prio_second");
        service();
        intr_active_i[2] = 1'b0; intr_active_i[9] = 1'b0;

        // Masked source and access errors
        apb_write(8'h04, 8'h00, 1'b0, "wr_prio4");
        intr_active_i[4] = 1'b1;
        tick(); tick(); tick();
        chk_win(1'b0, 4'd0, "masked_idle");
        apb_read(8'h10, 8'h10, 1'b0, "pend_masked");
        apb_write(8'h10, 8'hFF, 1'b1, "wr_pend_err");
        apb_read(8'h10, 8'h10, 1'b0, "pend_unchanged");
        apb_write(8'h12, 8'hFF, 1'b1, "wr_status_err");
        apb_read(8'h40, 8'h00, 1'b1, "rd_unmapped");
        intr_active_i[4] = 1'b0;

        // Equal-priority ties and no preemption
        apb_write(8'h01, 8'h03, 1'b0, "wr_prio1");
        apb_write(8'h06, 8'h03, 1'b0, "wr_prio6");
        apb_write(8'h07, 8'h0F, 1'b0, "wr_prio7");
        intr_active_i[1] = 1'b1; intr_active_i[6] = 1'b1;
        tick(); tick(); tick();
        chk_win(1'b1, 4'd1, "tie_first");
        service();
        tick(); tick();
        chk_win(1'b1, 4'd6, "tie_second");
        intr_active_i[1] = 1'b0; tick();
        intr_active_i[1] = 1'b1; tick();
        chk_win(1'b1, 4'd6, "tie_reraise_hold");
        service();
        tick(); tick();
        chk_win(1'b1, 4'd1, "tie_third");
        intr_active_i[7] = 1'b1;
        tick(); tick(); tick();
        chk_win(1'b1, 4'd1, "no_preempt");
        apb_read(8'h10, 8'h92, 1'b0, "pend_preempt");
        service();
        tick(); tick();
        chk_win(1'b1, 4'd7, "urgent_after");
        service();
        chk_win(1'b0, 4'd0, "urgent_done");
        intr_active_i[1] = 1'b0; intr_active_i[6] = 1'b0; intr_active_i[7] = 1'b0;

        // New edge on the serviced id in the clear cycle
        intr_active_i[3] = 1'b1;
        tick(); tick(); tick();
        chk_win(1'b1, 4'd3, "reissue_first");
        intr_active_i[3] = 1'b0; tick();
        intr_active_i[3] = 1'b1; intr_serviced_i = 1'b1;
        tick();
        intr_serviced_i = 1'b0;
        chk_win(1'b0, 4'd0, "reissue_gap");
        apb_read(8'h10, 8'h18, 1'b0, "pend_set_wins");
        tick();
        chk_win(1'b1, 4'd3, "reissue_again");

        // Reset during service
        prst_i = 1'b1; intr_active_i = '0;
        tick();
        chk("midrst_valid", 32'(intr_valid_o), 32'd0);
        chk("midrst_id", 32'(intr_to_service_o), 32'd0);
        prst_i = 1'b0;
        apb_read(8'h10, 8'h00, 1'b0, "midrst_pend");
        apb_read(8'h03, 8'h00, 1'b0, "midrst_prio");
        tick();
        chk_win(1'b0, 4'd0, "midrst_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
